down_counter_timer: RTL and testbench

//  Loadable WIDTH-bit synchronous down counter wrapped in a start/busy/done

---
 rtl/down_counter_timer.sv | 111 +++++++++++
 tb/tb_down_counter_timer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down counter wrapped in a start/busy/done FSM.
// A start in IDLE captures load_val into both the counter and a reload
// register. RUN decrements on enabled clocks until the count reaches zero.
// DONE lasts one cycle; from there the block either restarts from the
// captured value or returns to IDLE. busy, done and fsm_state are decoded
// straight from the state register, so no input reaches an output
// combinationally.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             reload_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] W_ZERO = '0;
  localparam logic [WIDTH-1:0] W_ONE  = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_next;

  // State register; clear forces IDLE without waiting for a clock edge.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Counter and reload registers; clear zeroes both asynchronously.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_count  <= W_ZERO;
      r_reload <= W_ZERO;
    end else begin
      r_count  <= w_count_next;
      r_reload <= w_reload_next;
    end
  end

  // Next-state and datapath decisions. Every branch starts from "hold".
  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_reload_next = r_reload;
    case (r_state)
      ST_IDLE: begin
        // stop beats start when both arrive together
        if (!stop && start) begin
          w_count_next  = load_val;
          w_reload_next = load_val;
          w_state_next  = (load_val != W_ZERO) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          // abort keeps the current count and raises no done
          w_state_next = ST_IDLE;
        end else if (enable) begin
          // guard against decrementing past zero, so the count never wraps
          if (r_count != W_ZERO) begin
            w_count_next = r_count - W_ONE;
          end
          if (r_count <= W_ONE) begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (stop) begin
          w_state_next = ST_IDLE;
        end else if (reload_en) begin
          // a zero reload value re-enters DONE, so done stays high
          w_count_next = r_reload;
          w_state_next = (r_reload != W_ZERO) ? ST_RUN : ST_DONE;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        // the unused encoding recovers to IDLE on the next edge
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign count     = r_count;
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign fsm_state = r_state;

endmodule

// File: tb/tb_down_counter_timer.sv
// Testbench for down_counter_timer (WIDTH=4).
// The stimulus process drives inputs on the falling edge. It steps a
// behavioural timer model and queues the outputs expected after the next
// rising edge. A separate monitor pops one entry per rising edge and compares.
// Asynchronous clear is also checked directly, before any clock edge.
module tb_down_counter_timer;

  logic       clk;
  logic       clear;
  logic       start;
  logic       stop;
  logic       enable;
  logic       reload_en;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic [1:0] fsm_state;

  typedef struct {
    logic [3:0] c;
    logic       b;
    logic       d;
    logic [1:0] s;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 = idle, 1 = counting, 2 = expired
  int         m_mode = 0;
  logic [3:0] m_cnt  = 4'd0;
  logic [3:0] m_rel  = 4'd0;

  down_counter_timer #(.WIDTH(4)) dut (
    .clock(clk),
    .clear(clear),
    .start(start),
    .stop(stop),
    .enable(enable),
    .reload_en(reload_en),
    .load_val(load_val),
    .count(count),
    .busy(busy),
    .done(done),
    .fsm_state(fsm_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the timer rules to one clock edge with the given inputs.
  task automatic model_step(input logic st, input logic sp, input logic en,
                            input logic re, input logic [3:0] lv,
                            input logic clr);
    if (clr) begin
      m_mode = 0;
      m_cnt  = 4'd0;
      m_rel  = 4'd0;
    end else if (m_mode == 0) begin
      if (!sp && st) begin
        m_cnt  = lv;
        m_rel  = lv;
        m_mode = (lv != 0) ? 1 : 2;
      end
    end else if (m_mode == 1) begin
      if (sp) begin
        m_mode = 0;
      end else if (en) begin
        m_cnt = m_cnt - 4'd1;
        if (m_cnt == 4'd0) m_mode = 2;
      end
    end else begin
      if (sp) begin
        m_mode = 0;
      end else if (re) begin
        m_cnt  = m_rel;
        m_mode = (m_rel != 0) ? 1 : 2;
      end else begin
        m_mode = 0;
      end
    end
  endtask

  // Drive one cycle of stimulus, then queue the expected outputs.
  task automatic cyc(input logic st, input logic sp, input logic en,
                     input logic re, input logic [3:0] lv, input logic clr);
    exp_t e;
    @(negedge clk);
    start     = st;
    stop      = sp;
    enable    = en;
    reload_en = re;
    load_val  = lv;
    clear     = clr;
    if (clr) begin
      #1;
      check("async_count", int'(count), 0);
      check("async_busy", int'(busy), 0);
      check("async_done", int'(done), 0);
      check("async_state", int'(fsm_state), 0);
    end
    model_step(st, sp, en, re, lv, clr);
    e.c = m_cnt;
    e.b = (m_mode == 1);
    e.d = (m_mode == 2);
    e.s = 2'(m_mode);
    sb.push_back(e);
  endtask

  // Monitor: compare the outputs with the oldest queued expectation after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("count", int'(count), int'(e.c));
        check("busy", int'(busy), int'(e.b));
        check("done", int'(done), int'(e.d));
        check("fsm_state", int'(fsm_state), int'(e.s));
      end
    end
  end

  initial begin
    int guard;
    start     = 1'b0;
    stop      = 1'b0;
    enable    = 1'b0;
    reload_en = 1'b0;
    load_val  = 4'd0;
    clear     = 1'b1;
    #1;
    check("reset_count", int'(count), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_state", int'(fsm_state), 0);
    cyc(0, 0, 0, 0, 4'd0, 1);
    cyc(0, 0, 0, 0, 4'd0, 0);

    // Test 1: clear asserted mid-RUN at count 5, held for two edges
    cyc(1, 0, 1, 0, 4'd9, 0);
    guard = 0;
    while (m_cnt != 4'd5 && guard < 20) begin
      cyc(0, 0, 1, 0, 4'd0, 0);
      guard++;
    end
    check("reach_count5", int'(m_cnt), 5);
    cyc(0, 0, 1, 0, 4'd0, 1);
    cyc(0, 0, 1, 0, 4'd0, 1);
    cyc(0, 0, 1, 0, 4'd0, 0);

    // Test 2: basic countdown from 3
    cyc(1, 0, 1, 0, 4'd3, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 4'd7, 0);

    // Test 3: enable low holds the count
    cyc(1, 0, 0, 0, 4'd2, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 4'd0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 4'd0, 0);

    // Test 4: auto-reload from 2, then drop reload_en
    cyc(1, 0, 1, 1, 4'd2, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, 4'd5, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 4'd5, 0);

    // Test 5: zero load, without and then with reload
    cyc(1, 0, 1, 0, 4'd0, 0);
    cyc(0, 0, 1, 0, 4'd0, 0);
    cyc(0, 0, 1, 0, 4'd0, 0);
    cyc(1, 0, 1, 1, 4'd0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 4'd0, 0);
    cyc(0, 0, 1, 0, 4'd0, 0);
    cyc(0, 0, 1, 0, 4'd0, 0);

    // Test 6: stop at count 7, start during RUN ignored, start+stop in IDLE
    cyc(1, 0, 1, 0, 4'd9, 0);
    cyc(0, 0, 1, 0, 4'd3, 0);
    cyc(0, 0, 1, 0, 4'd3, 0);
    cyc(0, 1, 1, 0, 4'd3, 0);
    cyc(0, 0, 1, 0, 4'd3, 0);
    cyc(1, 1, 1, 0, 4'd4, 0);
    cyc(1, 0, 1, 0, 4'd9, 0);
    cyc(1, 0, 1, 0, 4'd2, 0);
    cyc(1, 0, 1, 0, 4'd2, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 4'd1, 0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 5),
          ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 50),
          4'($urandom_range(0, 15)), ($urandom_range(0, 99) < 2));
    end

    cyc(0, 1, 0, 0, 4'd0, 0);
    @(posedge clk);
    #2;
    check("drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
